// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - op codes, state encoding and default latency for the HI/LO unit
package hilo_pkg;

  localparam logic [2:0] HILO_NOP  = 3'd0;
  localparam logic [2:0] HILO_DIV  = 3'd1;
  localparam logic [2:0] HILO_MFHI = 3'd2;
  localparam logic [2:0] HILO_MFLO = 3'd3;
  localparam logic [2:0] HILO_MTHI = 3'd4;
  localparam logic [2:0] HILO_MTLO = 3'd5;

  localparam int DIV_LATENCY_DEF = 4;
  localparam int CNT_W           = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } hilo_state_t;

endpackage

// File: rtl/hilo_busy_timer.sv
// rtl/hilo_busy_timer.sv - loadable down-counter; busy while nonzero, done in its last cycle
module hilo_busy_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             busy,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign busy = (count != '0);
  // done marks the cycle whose closing edge takes the count from 1 to 0
  assign done = (count == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/hilo_reg_unit.sv
// rtl/hilo_reg_unit.sv - HI/LO registers with modelled divide latency, MF/MT access and stall
module hilo_reg_unit
  import hilo_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int DIV_LATENCY = DIV_LATENCY_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  input  logic [2:0]      op_code,
  input  logic [XLEN-1:0] divisor,
  input  logic [XLEN-1:0] quotient,
  input  logic [XLEN-1:0] remainder,
  input  logic [XLEN-1:0] wdata,
  output logic            stall,
  output logic            busy,
  output logic [XLEN-1:0] rdata,
  output logic            rdata_valid,
  output logic            div_zero
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(DIV_LATENCY);

  hilo_state_t     state;
  logic [XLEN-1:0] hi, lo, pend_q, pend_r;
  logic            accept, divisor_zero, timer_load, timer_busy, timer_done;

  assign divisor_zero = (divisor == '0);
  // every real op waits out an outstanding divide: covers RAW, WAW and structural hazards
  assign stall        = op_valid & timer_busy & (op_code != HILO_NOP);
  assign accept       = op_valid & ~stall;
  assign timer_load   = (state == IDLE) & accept & (op_code == HILO_DIV) & ~divisor_zero;
  assign busy         = timer_busy;

  hilo_busy_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (LAT),
    .busy     (timer_busy),
    .done     (timer_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      hi          <= '0;
      lo          <= '0;
      pend_q      <= '0;
      pend_r      <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      div_zero    <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      div_zero    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (op_code)
              HILO_DIV: begin
                if (divisor_zero) begin
                  div_zero <= 1'b1;
                end else begin
                  pend_q <= quotient;
                  pend_r <= remainder;
                  state  <= BUSY;
                end
              end
              HILO_MFHI: begin
                rdata       <= hi;
                rdata_valid <= 1'b1;
              end
              HILO_MFLO: begin
                rdata       <= lo;
                rdata_valid <= 1'b1;
              end
              HILO_MTHI: hi <= wdata;
              HILO_MTLO: lo <= wdata;
              default: ;
            endcase
          end
        end
        BUSY: begin
          if (timer_done) begin
            lo    <= pend_q;
            hi    <= pend_r;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_reg_unit.sv
// tb/tb_hilo_reg_unit.sv - directed vector bench for hilo_reg_unit (latency 4 and latency 1 builds)
module tb_hilo_reg_unit;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            op_valid;
  logic [2:0]      op_code;
  logic [XLEN-1:0] divisor, quotient, remainder, wdata;

  logic            stall_a, busy_a, rv_a, dz_a;
  logic [XLEN-1:0] rd_a;
  logic            stall_b, busy_b, rv_b, dz_b;
  logic [XLEN-1:0] rd_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hilo_reg_unit #(.XLEN(XLEN), .DIV_LATENCY(4)) dut_a (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
    .divisor(divisor), .quotient(quotient), .remainder(remainder), .wdata(wdata),
    .stall(stall_a), .busy(busy_a), .rdata(rd_a), .rdata_valid(rv_a), .div_zero(dz_a)
  );

  hilo_reg_unit #(.XLEN(XLEN), .DIV_LATENCY(1)) dut_b (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
    .divisor(divisor), .quotient(quotient), .remainder(remainder), .wdata(wdata),
    .stall(stall_b), .busy(busy_b), .rdata(rd_b), .rdata_valid(rv_b), .div_zero(dz_b)
  );

  typedef struct {
    logic            vld;
    logic [2:0]      op;
    logic [XLEN-1:0] dvs;
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] r;
    logic [XLEN-1:0] wd;
    logic            e_stall;
    logic            e_busy;
    logic            e_rv;
    logic [XLEN-1:0] e_rd;
    logic            e_dz;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [XLEN-1:0] d,
                       input logic [XLEN-1:0] q, input logic [XLEN-1:0] r, input logic [XLEN-1:0] w);
    op_valid = v; op_code = op; divisor = d; quotient = q; remainder = r; wdata = w;
  endtask

  task automatic add(input logic v, input logic [2:0] op, input logic [XLEN-1:0] d,
                     input logic [XLEN-1:0] q, input logic [XLEN-1:0] r, input logic [XLEN-1:0] w,
                     input logic es, input logic eb, input logic erv, input logic [XLEN-1:0] erd,
                     input logic edz);
    vec_t t;
    t.vld = v; t.op = op; t.dvs = d; t.q = q; t.r = r; t.wd = w;
    t.e_stall = es; t.e_busy = eb; t.e_rv = erv; t.e_rd = erd; t.e_dz = edz;
    vq.push_back(t);
  endtask

  initial begin
    logic [XLEN-1:0] Q1, DB;
    Q1 = 64'hFFFF_FFFF_FFFF_FFFD;
    DB = 64'hDEAD_BEEF_0000_0001;

    // vld op  dvs q r wd   stall busy rv rdata dz   (busy/rv/rdata/dz observed after the edge)
    add(1, 3'd3, 0, 0, 0, 0,    0, 0, 1, 64'h0, 0);
    add(1, 3'd2, 0, 0, 0, 0,    0, 0, 1, 64'h0, 0);
    add(1, 3'd1, 2, Q1, 1, 0,   0, 1, 0, 64'h0, 0);
    add(1, 3'd3, 0, 0, 0, 0,    1, 1, 0, 64'h0, 0);
    add(1, 3'd3, 0, 0, 0, 0,    1, 1, 0, 64'h0, 0);
    add(1, 3'd3, 0, 0, 0, 0,    1, 1, 0, 64'h0, 0);
    add(1, 3'd3, 0, 0, 0, 0,    1, 0, 0, 64'h0, 0);
    add(1, 3'd3, 0, 0, 0, 0,    0, 0, 1, Q1, 0);
    add(1, 3'd2, 0, 0, 0, 0,    0, 0, 1, 64'h1, 0);
    add(1, 3'd4, 0, 0, 0, DB,   0, 0, 0, 64'h1, 0);
    add(1, 3'd5, 0, 0, 0, 5,    0, 0, 0, 64'h1, 0);
    add(1, 3'd1, 0, 99, 77, 0,  0, 0, 0, 64'h1, 1);
    add(1, 3'd0, 0, 0, 0, 0,    0, 0, 0, 64'h1, 0);
    add(1, 3'd2, 0, 0, 0, 0,    0, 0, 1, DB, 0);
    add(1, 3'd3, 0, 0, 0, 0,    0, 0, 1, 64'h5, 0);
    add(1, 3'd1, 7, 10, 3, 0,   0, 1, 0, 64'h5, 0);
    add(1, 3'd1, 5, 20, 4, 0,   1, 1, 0, 64'h5, 0);
    add(1, 3'd1, 5, 20, 4, 0,   1, 1, 0, 64'h5, 0);
    add(1, 3'd1, 5, 20, 4, 0,   1, 1, 0, 64'h5, 0);
    add(1, 3'd1, 5, 20, 4, 0,   1, 0, 0, 64'h5, 0);
    add(1, 3'd1, 5, 20, 4, 0,   0, 1, 0, 64'h5, 0);
    add(1, 3'd0, 0, 0, 0, 0,    0, 1, 0, 64'h5, 0);
    add(0, 3'd3, 0, 0, 0, 0,    0, 1, 0, 64'h5, 0);
    add(1, 3'd2, 0, 0, 0, 0,    1, 1, 0, 64'h5, 0);
    add(1, 3'd2, 0, 0, 0, 0,    1, 0, 0, 64'h5, 0);
    add(1, 3'd2, 0, 0, 0, 0,    0, 0, 1, 64'h4, 0);
    add(1, 3'd3, 0, 0, 0, 0,    0, 0, 1, 64'h14, 0);

    rst = 1'b1;
    drive(0, 3'd0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy",  {63'b0, busy_a}, 64'h0);
    chk("reset stall", {63'b0, stall_a}, 64'h0);
    chk("reset rdata", rd_a, 64'h0);
    chk("reset rv",    {63'b0, rv_a}, 64'h0);
    chk("reset dz",    {63'b0, dz_a}, 64'h0);
    chk("reset b busy", {63'b0, busy_b}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vq[i]) begin
      drive(vq[i].vld, vq[i].op, vq[i].dvs, vq[i].q, vq[i].r, vq[i].wd);
      @(negedge clk);
      chk($sformatf("v%0d stall", i), {63'b0, stall_a}, {63'b0, vq[i].e_stall});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d busy", i),  {63'b0, busy_a}, {63'b0, vq[i].e_busy});
      chk($sformatf("v%0d rv", i),    {63'b0, rv_a},   {63'b0, vq[i].e_rv});
      chk($sformatf("v%0d rdata", i), rd_a, vq[i].e_rd);
      chk($sformatf("v%0d dz", i),    {63'b0, dz_a},   {63'b0, vq[i].e_dz});
    end

    // reset two cycles into a divide
    drive(1, 3'd1, 3, 64'h7, 64'h9, 0);
    @(posedge clk);
    #1;
    drive(1, 3'd0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("mid busy before rst", {63'b0, busy_a}, 64'h1);
    drive(1, 3'd3, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("async rst busy",  {63'b0, busy_a}, 64'h0);
    chk("async rst stall", {63'b0, stall_a}, 64'h0);
    chk("async rst rdata", rd_a, 64'h0);
    chk("async rst rv",    {63'b0, rv_a}, 64'h0);
    chk("async rst dz",    {63'b0, dz_a}, 64'h0);
    drive(0, 3'd0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post rst busy c%0d", k), {63'b0, busy_a}, 64'h0);
    end
    drive(1, 3'd3, 0, 0, 0, 0);
    @(negedge clk);
    chk("post rst stall", {63'b0, stall_a}, 64'h0);
    @(posedge clk);
    #1;
    chk("post rst mflo rv", {63'b0, rv_a}, 64'h1);
    chk("post rst mflo",    rd_a, 64'h0);

    // latency-1 build
    drive(1, 3'd1, 3, 64'h1234, 64'h56, 0);
    @(negedge clk);
    chk("l1 div stall", {63'b0, stall_b}, 64'h0);
    @(posedge clk);
    #1;
    chk("l1 busy", {63'b0, busy_b}, 64'h1);
    drive(1, 3'd3, 0, 0, 0, 0);
    @(negedge clk);
    chk("l1 mflo stall", {63'b0, stall_b}, 64'h1);
    @(posedge clk);
    #1;
    chk("l1 busy drop", {63'b0, busy_b}, 64'h0);
    chk("l1 rv while stalled", {63'b0, rv_b}, 64'h0);
    @(negedge clk);
    chk("l1 mflo go", {63'b0, stall_b}, 64'h0);
    @(posedge clk);
    #1;
    chk("l1 mflo rv", {63'b0, rv_b}, 64'h1);
    chk("l1 mflo",    rd_b, 64'h1234);
    drive(1, 3'd2, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("l1 mfhi", rd_b, 64'h56);
    drive(0, 3'd0, 0, 0, 0, 0);
    @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
